// File: rtl/gpio_bus_wrapper.sv
// gpio_bus_wrapper
//   Pad wrapper that sits between a user core and the GPIO breakout ring.
//   It gates the whole wrapper on chip select and applies a static
//   per-pin direction mask. Pad inputs pass through synchronisers, and
//   pad outputs are registered. One contiguous bus field is bidirectional.
//   The core acquires that field with a request, and the field is driven
//   only after a programmable turnaround gap.
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-high
//   cs_n           chip select, active-low
//   gpio_in        pad inputs
//   gpio_out       pad outputs (registered)
//   gpio_oeb       pad output enables, active-low (registered)
//   core_en        registered copy of ~cs_n
//   core_in        synchronised pad inputs presented to the core
//   core_out       core output data
//   core_bus_req   core asks to drive the bus field
//   core_bus_grant bus field is currently driven from core_out

module gpio_bus_wrapper #(
  parameter int                    NUM_GPIO    = 34,
  parameter int                    BUS_LSB     = 26,
  parameter int                    BUS_W       = 8,
  parameter logic [NUM_GPIO-1:0]   OUT_MASK    = 'h000FFFF,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    TURNAROUND  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs_n,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oeb,
  output logic                core_en,
  output logic [NUM_GPIO-1:0] core_in,
  input  logic [NUM_GPIO-1:0] core_out,
  input  logic                core_bus_req,
  output logic                core_bus_grant
);

  typedef enum logic [1:0] {
    IDLE,
    LISTEN,
    TURN,
    DRIVE
  } state_t;

  function automatic logic [NUM_GPIO-1:0] make_bus_mask();
    logic [NUM_GPIO-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      if (i >= BUS_LSB && i < BUS_LSB + BUS_W) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NUM_GPIO-1:0] BUS_MASK    = make_bus_mask();
  // The bus field overrides the static mask, so its OUT_MASK bits are ignored.
  localparam logic [NUM_GPIO-1:0] STATIC_OUT  = OUT_MASK & ~BUS_MASK;
  localparam logic [NUM_GPIO-1:0] STATIC_OEB  = ~OUT_MASK & ~BUS_MASK;
  localparam logic [NUM_GPIO-1:0] IN_MASK     = ~STATIC_OUT;
  localparam logic [2:0]          TURN_LOAD   = (TURNAROUND == 0) ? 3'd0 : 3'(TURNAROUND - 1);

  state_t              state;
  state_t              next_state;
  logic [2:0]          cnt;
  logic [2:0]          next_cnt;
  logic [NUM_GPIO-1:0] next_oeb;
  logic [NUM_GPIO-1:0] next_out;
  logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];

  // Next-state logic. Inside every state, deselect wins over a dropped
  // request, and a dropped request wins over the turnaround count.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (!cs_n) next_state = LISTEN;
      end
      LISTEN: begin
        if (cs_n) begin
          next_state = IDLE;
        end else if (core_bus_req) begin
          if (TURNAROUND == 0) begin
            next_state = DRIVE;
          end else begin
            next_state = TURN;
            next_cnt   = TURN_LOAD;
          end
        end
      end
      TURN: begin
        if (cs_n)               next_state = IDLE;
        else if (!core_bus_req) next_state = LISTEN;
        else if (cnt == 3'd0)   next_state = DRIVE;
        else                    next_cnt   = cnt - 3'd1;
      end
      DRIVE: begin
        if (cs_n)               next_state = IDLE;
        else if (!core_bus_req) next_state = LISTEN;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pad values are decoded from the state being entered. This lets the
  // registered pads change on the same edge as the state. A release is
  // therefore visible on the very next edge.
  always_comb begin
    next_oeb = '1;
    next_out = '0;
    if (next_state != IDLE) begin
      next_oeb = STATIC_OEB | ((next_state == DRIVE) ? '0 : BUS_MASK);
      next_out = core_out & (STATIC_OUT | ((next_state == DRIVE) ? BUS_MASK : '0));
    end
  end

  // State, counter, registered pads and input synchronisers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      gpio_oeb       <= '1;
      gpio_out       <= '0;
      core_bus_grant <= 1'b0;
      core_en        <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      state          <= next_state;
      cnt            <= next_cnt;
      gpio_oeb       <= next_oeb;
      gpio_out       <= next_out;
      core_bus_grant <= (next_state == DRIVE);
      core_en        <= ~cs_n;
      sync_q[0]      <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // This output is driven only from registers. The core sees nothing
  // while the wrapper is deselected, and it never sees its own static
  // output pins.
  assign core_in = (state == IDLE) ? '0 : (sync_q[SYNC_STAGES-1] & IN_MASK);

endmodule

// File: tb/tb_gpio_bus_wrapper.sv
// tb_gpio_bus_wrapper
//   Bench for gpio_bus_wrapper. Three instances share one stimulus stream:
//     0: TURNAROUND=1, SYNC_STAGES=2 (defaults)
//     1: TURNAROUND=0, SYNC_STAGES=3
//     2: TURNAROUND=3, SYNC_STAGES=1
//   A behavioural model tracks how many consecutive edges the wrapper has
//   been selected and how many consecutive edges the request has been
//   held. Each instance's expected outputs are derived from those counts
//   and a history of pad inputs.

module tb_gpio_bus_wrapper;

  localparam logic [33:0] OUT_MASK_C = 34'h000FFFF;
  localparam logic [33:0] BUS_C      = 34'h3FC000000;
  localparam logic [33:0] ALL_ONES   = 34'h3FFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        req;
  logic [33:0] gpio_in;
  logic [33:0] core_out;

  logic [33:0] oeb_w   [3];
  logic [33:0] out_w   [3];
  logic [33:0] cin_w   [3];
  logic        en_w    [3];
  logic        grant_w [3];

  int ta_p [3] = '{1, 0, 3};
  int ss_p [3] = '{2, 3, 1};

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          model_valid = 1'b0;
  int          sel_len;
  int          req_len;
  logic [33:0] hist[$];
  logic [33:0] co_snap;
  logic        en_exp;

  always #5 clk = ~clk;

  gpio_bus_wrapper u_dut0 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .gpio_in(gpio_in),
    .gpio_out(out_w[0]), .gpio_oeb(oeb_w[0]), .core_en(en_w[0]),
    .core_in(cin_w[0]), .core_out(core_out), .core_bus_req(req),
    .core_bus_grant(grant_w[0])
  );

  gpio_bus_wrapper #(.TURNAROUND(0), .SYNC_STAGES(3)) u_dut1 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .gpio_in(gpio_in),
    .gpio_out(out_w[1]), .gpio_oeb(oeb_w[1]), .core_en(en_w[1]),
    .core_in(cin_w[1]), .core_out(core_out), .core_bus_req(req),
    .core_bus_grant(grant_w[1])
  );

  gpio_bus_wrapper #(.TURNAROUND(3), .SYNC_STAGES(1)) u_dut2 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .gpio_in(gpio_in),
    .gpio_out(out_w[2]), .gpio_oeb(oeb_w[2]), .core_en(en_w[2]),
    .core_in(cin_w[2]), .core_out(core_out), .core_bus_req(req),
    .core_bus_grant(grant_w[2])
  );

  task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model update on every rising edge.
  // Selection only counts from LISTEN onward, so a request edge counts
  // toward acquisition only if the wrapper was already selected before
  // that edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        sel_len = 0;
        req_len = 0;
        hist    = {};
        for (int k = 0; k < 4; k++) hist.push_back(34'h0);
        en_exp      = 1'b0;
        model_valid = 1'b1;
      end else begin
        if (!cs_n && req && sel_len >= 1) req_len = (req_len < 100) ? req_len + 1 : 100;
        else                              req_len = 0;
        if (!cs_n) sel_len = (sel_len < 100) ? sel_len + 1 : 100;
        else       sel_len = 0;
        hist.push_front(gpio_in);
        void'(hist.pop_back());
        en_exp = ~cs_n;
      end
      co_snap = core_out;
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 3; i++) begin
        bit          active;
        bit          grant;
        logic [33:0] e_oeb;
        logic [33:0] e_out;
        logic [33:0] e_cin;
        active = (sel_len >= 1);
        grant  = (req_len >= ta_p[i] + 1);
        e_oeb  = active ? ((~OUT_MASK_C & ~BUS_C) | (grant ? 34'h0 : BUS_C)) : ALL_ONES;
        e_out  = active ? (co_snap & ((OUT_MASK_C & ~BUS_C) | (grant ? BUS_C : 34'h0))) : 34'h0;
        e_cin  = active ? (hist[ss_p[i] - 1] & ~(OUT_MASK_C & ~BUS_C)) : 34'h0;
        checkOutput($sformatf("model_oeb%0d", i),   oeb_w[i], e_oeb);
        checkOutput($sformatf("model_out%0d", i),   out_w[i], e_out);
        checkOutput($sformatf("model_cin%0d", i),   cin_w[i], e_cin);
        checkOutput($sformatf("model_en%0d", i),    34'(en_w[i]), 34'(en_exp));
        checkOutput($sformatf("model_grant%0d", i), 34'(grant_w[i]), 34'(grant));
      end
    end
  end

  // Randomised traffic: the request is long-lived, with occasional
  // deselects and rare resets.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      gpio_in  = 34'({$urandom(), $urandom()});
      core_out = 34'({$urandom(), $urandom()});
      if ($urandom_range(0, 5) == 0) req = ~req;
      if (cs_n) cs_n = ($urandom_range(0, 2) != 0);
      else      cs_n = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 99) == 0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    cs_n     = 1'b1;
    req      = 1'b0;
    gpio_in  = 34'({$urandom(), $urandom()});
    core_out = 34'h0;
    repeat (2) @(posedge clk);

    // Reset with random pad inputs
    @(negedge clk);
    checkOutput("rst_oeb",   oeb_w[0], ALL_ONES);
    checkOutput("rst_out",   out_w[0], 34'h0);
    checkOutput("rst_cin",   cin_w[0], 34'h0);
    checkOutput("rst_grant", 34'(grant_w[0]), 34'h0);

    // Select
    rst      = 1'b0;
    cs_n     = 1'b0;
    core_out = ALL_ONES;
    @(negedge clk);
    checkOutput("sel_oeb", oeb_w[0], 34'h3FFFF0000);
    checkOutput("sel_out", out_w[0], 34'h000FFFF);
    checkOutput("sel_en",  34'(en_w[0]), 34'h1);

    // Acquire
    req      = 1'b1;
    core_out = {8'hA5, 26'h3FFFFFF};
    @(negedge clk);
    checkOutput("acq_t1_grant0", 34'(grant_w[0]), 34'h0);
    checkOutput("acq_t1_grant1", 34'(grant_w[1]), 34'h1);
    checkOutput("acq_t1_bus1",   34'(out_w[1][33:26]), 34'hA5);
    @(negedge clk);
    checkOutput("acq_t2_grant0", 34'(grant_w[0]), 34'h1);
    checkOutput("acq_t2_busoeb", 34'(oeb_w[0][33:26]), 34'h0);
    checkOutput("acq_t2_busout", 34'(out_w[0][33:26]), 34'hA5);

    // Release, then check the input latency on the bus pins
    req           = 1'b0;
    gpio_in[33:26] = 8'h3C;
    @(negedge clk);
    checkOutput("rel_grant0", 34'(grant_w[0]), 34'h0);
    checkOutput("rel_busoeb", 34'(oeb_w[0][33:26]), 34'hFF);
    @(negedge clk);
    checkOutput("lat2_cin0", 34'(cin_w[0][33:26]), 34'h3C);
    @(negedge clk);
    checkOutput("lat3_cin1", 34'(cin_w[1][33:26]), 34'h3C);

    // Deselect during turnaround, then reselect
    req = 1'b1;
    @(negedge clk);
    checkOutput("turn_grant0", 34'(grant_w[0]), 34'h0);
    cs_n = 1'b1;
    @(negedge clk);
    checkOutput("desel_oeb",   oeb_w[0], ALL_ONES);
    checkOutput("desel_grant", 34'(grant_w[0]), 34'h0);
    checkOutput("desel_cin",   cin_w[0], 34'h0);
    cs_n = 1'b0;
    @(negedge clk);
    checkOutput("resel_oeb",   oeb_w[0], 34'h3FFFF0000);
    checkOutput("resel_grant", 34'(grant_w[0]), 34'h0);

    applyStimulus(800);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
